bp_update_ctrl: RTL and testbench

- Sequences all writes into the branch predictor's shared BTB/BHT update port.
- Resolved branches from EX are queued in a small FIFO and drained at one update per cycle.
- On request, a table-clear walk invalidates every predictor index; fetch-side prediction is disabled for the duration.
- Maintains branch, mispredict and dropped-update statistics counters.

---
 rtl/bp_update_ctrl.sv | 153 +++++++++++++++
 tb/tb_bp_update_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_update_ctrl.sv
// Branch-predictor update sequencer: queues resolved EX branches, drains them
// one per cycle onto the shared BTB/BHT port, and runs the table-clear walk.
module bp_update_ctrl #(
    parameter int DEPTH = 4,
    parameter int IDX_W = 10,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic [31:0]      ex_pc,
    input  logic [31:0]      ex_target,
    input  logic             ex_taken,
    input  logic             ex_is_branch,
    input  logic             ex_predict_wrong,
    input  logic             clear_req,
    input  logic             cnt_clr,
    output logic             upd_valid,
    output logic [31:0]      upd_pc,
    output logic [31:0]      upd_target,
    output logic             upd_taken,
    output logic             upd_is_branch,
    output logic             upd_predict_wrong,
    output logic             clr_en,
    output logic [IDX_W-1:0] clr_idx,
    output logic             predict_en,
    output logic             busy,
    output logic             fifo_full,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispredict_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = 67;

    typedef enum logic {RUN = 1'b0, CLEAR = 1'b1} state_t;

    state_t           r_state, w_state_nxt;
    logic [EW-1:0]    r_mem [DEPTH];
    logic [PW-1:0]    r_wptr, r_rptr;
    logic [CW-1:0]    r_count;
    logic [IDX_W-1:0] r_clr_idx;
    logic             r_upd_valid;
    logic [EW-1:0]    r_upd_entry;
    logic [CNT_W-1:0] r_branch_cnt, r_mispredict_cnt, r_drop_cnt;

    logic [EW-1:0]    w_in, w_head;
    logic             w_push, w_full, w_empty, w_pop, w_bypass, w_accept, w_write;
    logic             w_clr_en, w_predict_en;

    assign w_in    = {ex_pc, ex_target, ex_taken, ex_is_branch, ex_predict_wrong};
    assign w_head  = r_mem[r_rptr];
    assign w_push  = ex_valid & (ex_is_branch | ex_predict_wrong);
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);

    // A beat is launched only if the next cycle is RUN, so a clear request never
    // shows an update beat inside CLEAR and the last CLEAR cycle primes the drain.
    assign w_pop    = (w_state_nxt == RUN) & ~w_empty;
    assign w_bypass = (w_state_nxt == RUN) & w_empty & w_push;
    assign w_accept = w_push & (~w_full | w_pop);
    assign w_write  = w_accept & ~w_bypass;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= RUN;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_clr_en     = 1'b0;
        w_predict_en = 1'b1;
        case (r_state)
            RUN: begin
                if (clear_req) w_state_nxt = CLEAR;
            end
            CLEAR: begin
                w_clr_en     = 1'b1;
                w_predict_en = 1'b0;
                if (r_clr_idx == {IDX_W{1'b1}}) w_state_nxt = RUN;
            end
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_clr_idx <= '0;
        else if (r_state == CLEAR) r_clr_idx <= r_clr_idx + IDX_W'(1);
        else r_clr_idx <= '0;
    end

    always_ff @(posedge clk) begin
        if (w_write) r_mem[r_wptr] <= w_in;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_write) r_wptr <= r_wptr + PW'(1);
            if (w_pop)   r_rptr <= r_rptr + PW'(1);
            r_count <= r_count + CW'(w_write) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_upd_valid <= 1'b0;
            r_upd_entry <= '0;
        end else begin
            r_upd_valid <= w_pop | w_bypass;
            if (w_pop)         r_upd_entry <= w_head;
            else if (w_bypass) r_upd_entry <= w_in;
            else               r_upd_entry <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_branch_cnt     <= '0;
            r_mispredict_cnt <= '0;
            r_drop_cnt       <= '0;
        end else if (cnt_clr) begin
            r_branch_cnt     <= '0;
            r_mispredict_cnt <= '0;
            r_drop_cnt       <= '0;
        end else begin
            if (w_accept & ex_is_branch)     r_branch_cnt     <= r_branch_cnt + CNT_W'(1);
            if (w_accept & ex_predict_wrong) r_mispredict_cnt <= r_mispredict_cnt + CNT_W'(1);
            if (w_push & ~w_accept)          r_drop_cnt       <= r_drop_cnt + CNT_W'(1);
        end
    end

    assign upd_valid         = r_upd_valid;
    assign upd_pc            = r_upd_entry[66:35];
    assign upd_target        = r_upd_entry[34:3];
    assign upd_taken         = r_upd_entry[2];
    assign upd_is_branch     = r_upd_valid & r_upd_entry[1];
    assign upd_predict_wrong = r_upd_valid & r_upd_entry[0];
    assign clr_en            = w_clr_en;
    assign clr_idx           = r_clr_idx;
    assign predict_en        = w_predict_en;
    assign busy              = (r_state == CLEAR) | ~w_empty;
    assign fifo_full         = w_full;
    assign branch_cnt        = r_branch_cnt;
    assign mispredict_cnt    = r_mispredict_cnt;
    assign drop_cnt          = r_drop_cnt;

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Scoreboard bench for bp_update_ctrl (DEPTH=4, IDX_W=3): expected update beats
// are queued as stimulus is driven and popped whenever the DUT emits a beat.
module tb_bp_update_ctrl;

    localparam int DEPTH = 4;
    localparam int IDX_W = 3;
    localparam int CNT_W = 32;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
        logic        taken;
        logic        br;
        logic        pw;
    } entry_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             ex_valid = 1'b0;
    logic [31:0]      ex_pc = '0;
    logic [31:0]      ex_target = '0;
    logic             ex_taken = 1'b0;
    logic             ex_is_branch = 1'b0;
    logic             ex_predict_wrong = 1'b0;
    logic             clear_req = 1'b0;
    logic             cnt_clr = 1'b0;
    logic             upd_valid;
    logic [31:0]      upd_pc;
    logic [31:0]      upd_target;
    logic             upd_taken;
    logic             upd_is_branch;
    logic             upd_predict_wrong;
    logic             clr_en;
    logic [IDX_W-1:0] clr_idx;
    logic             predict_en;
    logic             busy;
    logic             fifo_full;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispredict_cnt;
    logic [CNT_W-1:0] drop_cnt;

    bp_update_ctrl #(.DEPTH(DEPTH), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_target(ex_target),
        .ex_taken(ex_taken), .ex_is_branch(ex_is_branch),
        .ex_predict_wrong(ex_predict_wrong),
        .clear_req(clear_req), .cnt_clr(cnt_clr),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
        .upd_taken(upd_taken), .upd_is_branch(upd_is_branch),
        .upd_predict_wrong(upd_predict_wrong),
        .clr_en(clr_en), .clr_idx(clr_idx), .predict_en(predict_en),
        .busy(busy), .fifo_full(fifo_full),
        .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    entry_t      sb[$];
    logic [31:0] m_br = '0;
    logic [31:0] m_mp = '0;
    logic [31:0] m_drop = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ex_valid  = 1'b0;
        clear_req = 1'b0;
        cnt_clr   = 1'b0;
    endtask

    // Drives one push for the current cycle; acc says whether it should be queued.
    task automatic drive_push(input logic [31:0] pc, input logic [31:0] tgt,
                              input logic tk, input logic br, input logic pw, input bit acc);
        entry_t e;
        ex_valid = 1'b1; ex_pc = pc; ex_target = tgt;
        ex_taken = tk; ex_is_branch = br; ex_predict_wrong = pw;
        e = '{pc: pc, target: tgt, taken: tk, br: br, pw: pw};
        if (acc) begin
            sb.push_back(e);
            m_br = m_br + 32'(br);
            m_mp = m_mp + 32'(pw);
        end else begin
            m_drop = m_drop + 32'd1;
        end
    endtask

    task automatic check_cnts(input string tag);
        check({tag, "_br"},   64'(branch_cnt),     64'(m_br));
        check({tag, "_mp"},   64'(mispredict_cnt), 64'(m_mp));
        check({tag, "_drop"}, 64'(drop_cnt),       64'(m_drop));
    endtask

    always @(negedge clk) begin
        if (rst && upd_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_upd", 64'(upd_pc), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                entry_t e;
                e = sb.pop_front();
                check("upd_pc",     64'(upd_pc),     64'(e.pc));
                check("upd_target", 64'(upd_target), 64'(e.target));
                check("upd_flags",  64'({upd_taken, upd_is_branch, upd_predict_wrong}),
                                    64'({e.taken, e.br, e.pw}));
            end
        end
        if (rst && upd_valid && clr_en) check("upd_in_clear", 64'(1), 64'(0));
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        repeat (3) @(posedge clk);
        #1;
        check("rst_upd_valid",  64'(upd_valid),  64'(0));
        check("rst_predict_en", 64'(predict_en), 64'(1));
        check("rst_clr_en",     64'(clr_en),     64'(0));
        check("rst_busy",       64'(busy),       64'(0));
        check_cnts("rst");
        rst = 1'b1;
        tick();

        // Single update with one-cycle latency
        drive_push(32'h100, 32'h200, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        idle();
        check("single_valid", 64'(upd_valid), 64'(1));
        check_cnts("single");
        tick();
        check("single_one_beat", 64'(upd_valid), 64'(0));

        // Streaming: six back-to-back pushes drain with no bubbles
        for (int i = 0; i < 6; i++) begin
            drive_push(32'(i * 4), 32'h1000 + 32'(i), 1'(i), 1'b1, 1'(i == 2), 1'b1);
            tick();
            check("stream_valid", 64'(upd_valid), 64'(1));
            check("stream_full",  64'(fifo_full), 64'(0));
        end
        idle();
        tick();
        check("stream_done", 64'(upd_valid), 64'(0));
        check_cnts("stream");

        // Clear walk, with a second clear_req mid-walk that must be ignored
        check("pre_clear_pe", 64'(predict_en), 64'(1));
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("clr_en",   64'(clr_en),     64'(1));
            check("clr_idx",  64'(clr_idx),    64'(i));
            check("clr_pe",   64'(predict_en), 64'(0));
            clear_req = (i == 4);
            tick();
            clear_req = 1'b0;
        end
        check("post_clr_en",  64'(clr_en),     64'(0));
        check("post_clr_pe",  64'(predict_en), 64'(1));
        check("post_clr_idx", 64'(clr_idx),    64'(0));
        tick();
        check("no_restart", 64'(clr_en), 64'(0));

        // Overflow during clear: four queued, two dropped
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive_push(32'h2000 + 32'(i * 4), 32'h3000 + 32'(i), 1'b0, 1'b1, 1'b0, i < 4);
            tick();
            if (i == 3) check("ovf_full", 64'(fifo_full), 64'(1));
        end
        idle();
        check_cnts("ovf");
        tick();
        tick();
        check("ovf_resume_valid", 64'(upd_valid),  64'(1));
        check("ovf_resume_pe",    64'(predict_en), 64'(1));
        repeat (4) tick();
        check("ovf_drained", 64'(sb.size()), 64'(0));
        check("ovf_idle",    64'(busy),      64'(0));

        // Full FIFO with a same-cycle pop in the last CLEAR cycle still accepts
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_push(32'h4000 + 32'(i * 4), 32'h5000, 1'b1, 1'b0, 1'b1, 1'b1);
            tick();
        end
        idle();
        repeat (3) tick();
        check("fp_last_idx", 64'(clr_idx), 64'(7));
        drive_push(32'h4444, 32'h5555, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        idle();
        check("fp_full_kept", 64'(fifo_full), 64'(1));
        check_cnts("fp");
        repeat (6) tick();
        check("fp_drained", 64'(sb.size()), 64'(0));

        // clear_req coinciding with a drain beat: beat completes, then CLEAR
        drive_push(32'h600, 32'h700, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        check("cvd_beat", 64'(upd_valid), 64'(1));
        drive_push(32'h604, 32'h704, 1'b0, 1'b1, 1'b0, 1'b1);
        clear_req = 1'b1;
        tick();
        idle();
        check("cvd_clear",  64'(clr_en),    64'(1));
        check("cvd_paused", 64'(upd_valid), 64'(0));
        repeat (8) tick();
        check("cvd_resume", 64'(upd_valid), 64'(1));
        tick();
        check("cvd_drained", 64'(sb.size()), 64'(0));

        // Filtering and counter clear priority
        ex_valid = 1'b1; ex_is_branch = 1'b0; ex_predict_wrong = 1'b0; ex_pc = 32'hDEAD;
        tick();
        idle();
        check("filt_no_beat", 64'(upd_valid), 64'(0));
        check_cnts("filt");
        drive_push(32'h800, 32'h900, 1'b1, 1'b1, 1'b1, 1'b1);
        cnt_clr = 1'b1;
        m_br = '0; m_mp = '0; m_drop = '0;
        tick();
        idle();
        check_cnts("cclr");
        tick();

        // Reset in the middle of a clear walk with two entries queued
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        drive_push(32'hA00, 32'hB00, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        drive_push(32'hA04, 32'hB04, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        idle();
        tick();
        check("rmc_idx", 64'(clr_idx), 64'(3));
        rst = 1'b0;
        #1;
        sb.delete();
        m_br = '0; m_mp = '0; m_drop = '0;
        check("rmc_clr_en", 64'(clr_en),     64'(0));
        check("rmc_pe",     64'(predict_en), 64'(1));
        check("rmc_busy",   64'(busy),       64'(0));
        check("rmc_upd",    64'(upd_valid),  64'(0));
        check_cnts("rmc");
        tick();
        rst = 1'b1;
        repeat (3) tick();
        check("rmc_after_upd",  64'(upd_valid), 64'(0));
        check("rmc_after_busy", 64'(busy),      64'(0));
        check("final_sb_empty", 64'(sb.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
